// File: rtl/frame_index_sequencer_if.sv
// Stream bundle for frame_index_sequencer: upstream sample handshake and the
// indexed downstream sample handshake. The sequencer uses master, its environment uses slave.
interface frame_index_sequencer_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 12
);
    logic                     s_valid;
    logic [DATA_WIDTH-1:0]    s_data;
    logic                     s_ready;
    logic                     m_valid;
    logic [DATA_WIDTH-1:0]    m_data;
    logic [CONTROL_WIDTH-1:0] m_index;
    logic                     m_first;
    logic                     m_last;
    logic                     m_ready;

    modport master (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_index, m_first, m_last
    );

    modport slave (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_index, m_first, m_last
    );
endinterface

// File: rtl/frame_index_sequencer.sv
// Registered stream stage tagging each sample with its position in a fixed-length frame,
// gated to whole frames by start/stop. Optional frame counter: define FRAME_COUNT_EN.
module frame_index_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int CONTROL_WIDTH = 12,
    parameter int FRAME_LEN     = 4096
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic stop,
    frame_index_sequencer_if.master bus,
    output logic busy
`ifdef FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [CONTROL_WIDTH-1:0] LAST_IDX = CONTROL_WIDTH'(FRAME_LEN - 1);

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic [CONTROL_WIDTH-1:0] idx;
    logic                     accept;
    logic                     last_accept;

    logic                     m_valid_q;
    logic [DATA_WIDTH-1:0]    m_data_q;
    logic [CONTROL_WIDTH-1:0] m_index_q;
    logic                     m_first_q;
    logic                     m_last_q;

    assign bus.s_ready  = (state != IDLE) && (!m_valid_q || bus.m_ready);
    assign accept       = bus.s_valid && bus.s_ready;
    assign last_accept  = accept && (idx == LAST_IDX);
    assign busy         = (state != IDLE);

    assign bus.m_valid  = m_valid_q;
    assign bus.m_data   = m_data_q;
    assign bus.m_index  = m_index_q;
    assign bus.m_first  = m_first_q;
    assign bus.m_last   = m_last_q;

    // DRAIN itself records the pending stop; start there cancels it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (stop) state_nxt = last_accept ? IDLE : DRAIN;
            DRAIN: begin
                if (start)            state_nxt = RUN;
                else if (last_accept) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                idx <= '0;
            else if (accept)
                idx <= (idx == LAST_IDX) ? '0 : idx + CONTROL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_index_q <= '0;
            m_first_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (accept) begin
            m_valid_q <= 1'b1;
            m_data_q  <= bus.s_data;
            m_index_q <= idx;
            m_first_q <= (idx == '0);
            m_last_q  <= (idx == LAST_IDX);
        end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
        end
    end

`ifdef FRAME_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            frame_count <= '0;
        else if (last_accept)
            frame_count <= frame_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_frame_index_sequencer.sv
// Directed, table-driven bench for frame_index_sequencer with FRAME_LEN=8.
module tb_frame_index_sequencer;

    localparam int DW = 32;
    localparam int CW = 12;
    localparam int FL = 8;

    typedef struct {
        logic          start;
        logic          stop;
        logic          s_valid;
        logic [DW-1:0] s_data;
        logic          m_ready;
        logic          e_s_ready;
        logic          e_m_valid;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_index;
        logic          e_first;
        logic          e_last;
        logic          e_busy;
    } vec_t;

    logic clk;
    logic reset_n;
    logic start;
    logic stop;
    logic busy;
`ifdef FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    int checks;
    int failures;

    frame_index_sequencer_if #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW)) bus ();

    frame_index_sequencer #(
        .DATA_WIDTH   (DW),
        .CONTROL_WIDTH(CW),
        .FRAME_LEN    (FL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .start  (start),
        .stop   (stop),
        .bus    (bus.master),
        .busy   (busy)
`ifdef FRAME_COUNT_EN
        ,
        .frame_count(frame_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    function automatic vec_t mk(input logic st, input logic sp, input logic sv, input int sd,
                                input logic mr, input logic esr, input logic emv, input int ed,
                                input int ei, input logic ef, input logic el, input logic eb);
        vec_t v;
        v.start = st; v.stop = sp; v.s_valid = sv; v.s_data = DW'(sd); v.m_ready = mr;
        v.e_s_ready = esr; v.e_m_valid = emv; v.e_data = DW'(ed); v.e_index = CW'(ei);
        v.e_first = ef; v.e_last = el; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input int tag, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step%0d: got %0h required %0h", nm, tag, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int tag);
        start       = v.start;
        stop        = v.stop;
        bus.s_valid = v.s_valid;
        bus.s_data  = v.s_data;
        bus.m_ready = v.m_ready;
        #1;
        chk(tag, "s_ready", 32'(bus.s_ready), 32'(v.e_s_ready));
        @(posedge clk);
        #1;
        chk(tag, "m_valid", 32'(bus.m_valid), 32'(v.e_m_valid));
        chk(tag, "m_data",  bus.m_data,       v.e_data);
        chk(tag, "m_index", 32'(bus.m_index), 32'(v.e_index));
        chk(tag, "m_first", 32'(bus.m_first), 32'(v.e_first));
        chk(tag, "m_last",  32'(bus.m_last),  32'(v.e_last));
        chk(tag, "busy",    32'(busy),        32'(v.e_busy));
    endtask

    task automatic do_reset();
        start       = 1'b0;
        stop        = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;
        reset_n     = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic chk_zero(input int tag);
        chk(tag, "rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk(tag, "rst_m_data",  bus.m_data,       32'd0);
        chk(tag, "rst_m_index", 32'(bus.m_index), 32'd0);
        chk(tag, "rst_m_first", 32'(bus.m_first), 32'd0);
        chk(tag, "rst_m_last",  32'(bus.m_last),  32'd0);
        chk(tag, "rst_busy",    32'(busy),        32'd0);
        chk(tag, "rst_s_ready", 32'(bus.s_ready), 32'd0);
    endtask

    initial begin
        vec_t tbl[$];
        checks   = 0;
        failures = 0;

        // Frame of A0..A7, one stall-free pass, then output drains.
        tbl.push_back(mk(1,0,0,0,1, 0, 0,0,0,0,0,1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,1,'hA0+i,1, 1, 1,'hA0+i,i,i==0,i==7,1));
        tbl.push_back(mk(0,0,0,0,1, 1, 0,'hA7,7,0,1,1));
        // Stop at index 3: frame finishes, then IDLE ignores s_valid.
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,i==3,1,'hD0+i,1, 1, 1,'hD0+i,i,i==0,i==7,i!=7));
        tbl.push_back(mk(0,0,1,'hEE,1, 0, 0,'hD7,7,0,1,0));
        // Restart (s_valid ignored while IDLE), stop coincides with index 7.
        tbl.push_back(mk(1,0,1,'hFF,1, 0, 0,'hD7,7,0,1,1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,i==7,1,'h10+i,1, 1, 1,'h10+i,i,i==0,i==7,i!=7));
        tbl.push_back(mk(0,0,0,0,1, 0, 0,'h17,7,0,1,0));
        // Start+stop together in IDLE: run, no drain.
        tbl.push_back(mk(1,1,0,0,1, 0, 0,'h17,7,0,1,1));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,1,'h20+i,1, 1, 1,'h20+i,i,i==0,i==7,1));
        // Stop at index 2, start at index 3 cancels it; frame wraps to 0.
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(i==3,i==2,1,'h30+i,1, 1, 1,'h30+i,i%8,(i%8)==0,i==7,1));
        tbl.push_back(mk(0,0,0,0,1, 1, 0,'h38,0,1,0,1));

        // Reset state
        start = 1'b0; stop = 1'b0;
        bus.s_valid = 1'b1; bus.s_data = 32'h55; bus.m_ready = 1'b1;
        reset_n = 1'b0;
        #3;
        chk_zero(0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        bus.s_valid = 1'b0;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], i + 1);

        // Continuous 20-sample stream from a fresh reset
        do_reset();
        apply(mk(1,0,0,0,1, 0, 0,0,0,0,0,1), 200);
        for (int i = 0; i < 20; i++)
            apply(mk(0,0,1,'hC0+i,1, 1, 1,'hC0+i,i%8,(i%8)==0,(i%8)==7,1), 201 + i);
`ifdef FRAME_COUNT_EN
        chk(221, "frame_count", 32'(frame_count), 32'd2);
`endif

        // Back-pressure holding index 2
        do_reset();
        apply(mk(1,0,0,0,1, 0, 0,0,0,0,0,1), 300);
        for (int i = 0; i < 3; i++)
            apply(mk(0,0,1,'hB0+i,1, 1, 1,'hB0+i,i,i==0,0,1), 301 + i);
        for (int i = 0; i < 5; i++)
            apply(mk(0,0,1,'hB3,0, 0, 1,'hB2,2,0,0,1), 310 + i);
        apply(mk(0,0,1,'hB3,1, 1, 1,'hB3,3,0,0,1), 320);
        apply(mk(0,0,0,0,1, 1, 0,'hB3,3,0,0,1), 321);

        // Asynchronous reset between edges at index 5
        do_reset();
        apply(mk(1,0,0,0,1, 0, 0,0,0,0,0,1), 400);
        for (int i = 0; i < 6; i++)
            apply(mk(0,0,1,'h60+i,1, 1, 1,'h60+i,i,i==0,0,1), 401 + i);
        #3;
        reset_n = 1'b0;
        #1;
        chk_zero(410);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        apply(mk(1,0,0,0,1, 0, 0,0,0,0,0,1), 411);
        apply(mk(0,0,1,'h77,1, 1, 1,'h77,0,1,0,1), 412);
`ifdef FRAME_COUNT_EN
        chk(413, "frame_count_rst", 32'(frame_count), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
